// File: rtl/st7735s_init_seq_pkg.sv
// Shared types for the ST7735S init/fill sequencer: FSM states, opcodes,
// and the init-table entry format.
package st7735s_init_seq_pkg;

  typedef enum logic [3:0] {
    IDLE, LOAD, SEND, HOLD, WAIT, DELAY, READY, FILL_CMD, FILL_PIX
  } state_t;

  localparam logic [7:0] SWRESET = 8'h01;
  localparam logic [7:0] SLPOUT  = 8'h11;
  localparam logic [7:0] COLMOD  = 8'h3A;
  localparam logic [7:0] MADCTL  = 8'h36;
  localparam logic [7:0] CASET   = 8'h2A;
  localparam logic [7:0] RASET   = 8'h2B;
  localparam logic [7:0] DISPON  = 8'h29;
  localparam logic [7:0] RAMWR   = 8'h2C;

  typedef struct packed {
    logic       is_cmd;
    logic [7:0] data;
    logic [7:0] delay_ms;
  } init_entry_t;

  localparam logic [4:0] INIT_LAST = 5'd16;

  function automatic init_entry_t cmd(input logic [7:0] op, input logic [7:0] ms);
    cmd = '{is_cmd: 1'b1, data: op, delay_ms: ms};
  endfunction

  function automatic init_entry_t arg(input logic [7:0] val);
    arg = '{is_cmd: 1'b0, data: val, delay_ms: 8'd0};
  endfunction

endpackage

// File: rtl/st7735s_init_rom.sv
// Combinational init table: one entry per byte, delay attached to the byte
// after which the panel needs settling time.
module st7735s_init_rom
  import st7735s_init_seq_pkg::*;
#(
  parameter int unsigned c_WIDTH  = 128,
  parameter int unsigned c_HEIGHT = 160
) (
  input  logic [4:0]  addr,
  output init_entry_t entry
);

  always_comb begin
    entry = '0;
    case (addr)
      5'd0:    entry = cmd(SWRESET, 8'd150);
      5'd1:    entry = cmd(SLPOUT, 8'd120);
      5'd2:    entry = cmd(COLMOD, 8'd0);
      5'd3:    entry = arg(8'h05);
      5'd4:    entry = cmd(MADCTL, 8'd0);
      5'd5:    entry = arg(8'h00);
      5'd6:    entry = cmd(CASET, 8'd0);
      5'd7:    entry = arg(8'h00);
      5'd8:    entry = arg(8'h00);
      5'd9:    entry = arg(8'h00);
      5'd10:   entry = arg(8'(c_WIDTH - 1));
      5'd11:   entry = cmd(RASET, 8'd0);
      5'd12:   entry = arg(8'h00);
      5'd13:   entry = arg(8'h00);
      5'd14:   entry = arg(8'h00);
      5'd15:   entry = arg(8'(c_HEIGHT - 1));
      5'd16:   entry = cmd(DISPON, 8'd10);
      default: entry = '0;
    endcase
  end

endmodule

// File: rtl/st7735s_init_seq.sv
// ST7735S panel sequencer: plays the init table into the SPI driver after
// reset, then fills the whole panel with a solid RGB565 colour on request.
module st7735s_init_seq
  import st7735s_init_seq_pkg::*;
#(
  parameter int unsigned c_CLKS_PER_MS = 50000,
  parameter int unsigned c_WIDTH       = 128,
  parameter int unsigned c_HEIGHT      = 160
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_waiting,
  output logic        o_ncommand,
  output logic [7:0]  o_data,
  output logic        o_data_rdy,
  input  logic        i_fill_start,
  input  logic [15:0] i_color,
  output logic        o_ready
);

  localparam logic [14:0] PIXELS = 15'(c_WIDTH * c_HEIGHT);

  state_t      state, state_next;
  init_entry_t entry;
  logic [4:0]  idx;
  logic [31:0] delay_cnt;
  logic        hold_cnt;
  logic [14:0] pix;
  logic        lo;
  logic        filling;
  logic [15:0] color;

  logic        latch;
  logic [7:0]  latch_data;
  logic        latch_ncmd;
  logic        idx_inc;
  logic        fill_accept;
  logic        fill_done;

  st7735s_init_rom #(
    .c_WIDTH (c_WIDTH),
    .c_HEIGHT(c_HEIGHT)
  ) u_rom (
    .addr (idx),
    .entry(entry)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // WAIT is shared by init and fill; the filling flag picks the successor.
  always_comb begin
    state_next  = state;
    latch       = 1'b0;
    latch_data  = '0;
    latch_ncmd  = 1'b0;
    idx_inc     = 1'b0;
    fill_accept = 1'b0;
    fill_done   = 1'b0;
    case (state)
      IDLE: state_next = LOAD;
      LOAD: if (i_waiting) begin
        state_next = SEND;
        latch      = 1'b1;
        latch_data = entry.data;
        latch_ncmd = ~entry.is_cmd;
      end
      SEND: state_next = HOLD;
      HOLD: if (hold_cnt) state_next = WAIT;
      WAIT: if (i_waiting) begin
        if (filling) begin
          if (pix == PIXELS) begin
            state_next = READY;
            fill_done  = 1'b1;
          end else begin
            state_next = FILL_PIX;
          end
        end else if (delay_cnt != '0) begin
          state_next = DELAY;
        end else if (idx == INIT_LAST) begin
          state_next = READY;
        end else begin
          idx_inc    = 1'b1;
          state_next = LOAD;
        end
      end
      DELAY: if (delay_cnt == '0) begin
        if (idx == INIT_LAST) begin
          state_next = READY;
        end else begin
          idx_inc    = 1'b1;
          state_next = LOAD;
        end
      end
      READY: if (i_fill_start) begin
        fill_accept = 1'b1;
        state_next  = FILL_CMD;
      end
      FILL_CMD: if (i_waiting) begin
        state_next = SEND;
        latch      = 1'b1;
        latch_data = RAMWR;
        latch_ncmd = 1'b0;
      end
      FILL_PIX: if (i_waiting) begin
        state_next = SEND;
        latch      = 1'b1;
        latch_data = lo ? color[7:0] : color[15:8];
        latch_ncmd = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data     <= '0;
      o_ncommand <= 1'b0;
      idx        <= '0;
      delay_cnt  <= '0;
      hold_cnt   <= 1'b0;
      pix        <= '0;
      lo         <= 1'b0;
      filling    <= 1'b0;
      color      <= '0;
    end else begin
      if (latch) begin
        o_data     <= latch_data;
        o_ncommand <= latch_ncmd;
      end
      if (state == LOAD && latch)
        delay_cnt <= 32'(entry.delay_ms) * c_CLKS_PER_MS;
      else if (state == DELAY && delay_cnt != '0)
        delay_cnt <= delay_cnt - 32'd1;
      if (state == SEND)      hold_cnt <= 1'b0;
      else if (state == HOLD) hold_cnt <= 1'b1;
      if (idx_inc) idx <= idx + 5'd1;
      if (fill_accept) begin
        color   <= i_color;
        filling <= 1'b1;
      end
      if (fill_done) filling <= 1'b0;
      if (state == FILL_CMD && latch) begin
        pix <= '0;
        lo  <= 1'b0;
      end
      // A pixel counts as sent once its low byte has gone out.
      if (state == FILL_PIX && latch) begin
        lo <= ~lo;
        if (lo) pix <= pix + 15'd1;
      end
    end
  end

  assign o_data_rdy = (state == SEND);
  assign o_ready    = (state == READY);

endmodule

// File: tb/tb_st7735s_init_seq.sv
// Directed bench for st7735s_init_seq with a behavioural SPI-driver busy model
// and a byte log of every strobe.
module tb_st7735s_init_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_waiting;
  logic        o_ncommand;
  logic [7:0]  o_data;
  logic        o_data_rdy;
  logic        i_fill_start;
  logic [15:0] i_color;
  logic        o_ready;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [8:0] log_q[$];
  int         log_cyc[$];
  int         busy_len   = 3;
  int         busy       = 0;
  int         violations = 0;
  int         min_gap    = 1000000;
  int         last_cyc   = -1;

  st7735s_init_seq #(
    .c_CLKS_PER_MS(10),
    .c_WIDTH      (4),
    .c_HEIGHT     (2)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_waiting   (i_waiting),
    .o_ncommand  (o_ncommand),
    .o_data      (o_data),
    .o_data_rdy  (o_data_rdy),
    .i_fill_start(i_fill_start),
    .i_color     (i_color),
    .o_ready     (o_ready)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream driver model: busy for busy_len cycles after each strobe.
  initial begin
    i_waiting = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy      = 0;
        i_waiting = 1'b1;
        last_cyc  = -1;
      end else if (o_data_rdy) begin
        if (!i_waiting) violations++;
        log_q.push_back({o_ncommand, o_data});
        log_cyc.push_back(cyc);
        if (last_cyc >= 0 && (cyc - last_cyc) < min_gap) min_gap = cyc - last_cyc;
        last_cyc  = cyc;
        i_waiting = 1'b0;
        busy      = busy_len;
      end else if (busy > 1) begin
        busy--;
      end else begin
        busy      = 0;
        i_waiting = 1'b1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo_b, input int hi_b);
    total++;
    assert (obs >= lo_b && obs <= hi_b) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=[%0d..%0d]", tag, obs, lo_b, hi_b);
    end
  endtask

  function automatic logic [8:0] log_at(input int i);
    if (i < log_q.size()) return log_q[i];
    return 9'h1FF;
  endfunction

  task automatic wait_ready(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (o_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_fill(input string tag, input logic [7:0] hi, input logic [7:0] lo);
    check({tag, "_len"}, log_q.size(), 17);
    check({tag, "_ramwr"}, log_at(0), 9'h02C);
    for (int k = 1; k < 17; k++)
      check($sformatf("%s_pix%0d", tag, k), log_at(k), (k % 2 == 1) ? {1'b1, hi} : {1'b1, lo});
  endtask

  logic [8:0] exp_init[17];
  bit         ok;
  int         ready_cyc;

  initial begin
    exp_init = '{9'h001, 9'h011, 9'h03A, 9'h105, 9'h036, 9'h100, 9'h02A, 9'h100, 9'h100,
                 9'h100, 9'h103, 9'h02B, 9'h100, 9'h100, 9'h100, 9'h101, 9'h029};
    rst          = 1'b1;
    i_fill_start = 1'b0;
    i_color      = 16'h0000;
    repeat (3) tick();

    check("rst_data_rdy", o_data_rdy, 1'b0);
    check("rst_ncommand", o_ncommand, 1'b0);
    check("rst_data", o_data, 8'h00);
    check("rst_ready", o_ready, 1'b0);

    // Init sequence, with a fill request issued mid-delay that must be ignored.
    rst = 1'b0;
    ok  = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      tick();
      if (i == 300) i_fill_start = 1'b1;
      if (i == 301) i_fill_start = 1'b0;
      if (o_ready) begin
        ok = 1'b1;
        break;
      end
    end
    ready_cyc = cyc;
    check("init_ready_timeout", ok, 1'b1);
    check("init_len", log_q.size(), 17);
    for (int k = 0; k < 17; k++) check($sformatf("init_byte%0d", k), log_at(k), exp_init[k]);
    if (log_cyc.size() >= 17) begin
      check_range("swreset_gap", log_cyc[1] - log_cyc[0], 1500, 1520);
      check_range("dispon_to_ready", ready_cyc - log_cyc[16], 100, 110);
    end else begin
      check("init_log_short", log_cyc.size(), 17);
    end

    // Red fill; colour changes and a second request mid-fill have no effect.
    log_q.delete();
    log_cyc.delete();
    i_color      = 16'hF800;
    i_fill_start = 1'b1;
    tick();
    i_fill_start = 1'b0;
    i_color      = 16'h1234;
    check("fill_ready_clear", o_ready, 1'b0);
    for (int i = 0; i < 200 && log_q.size() < 6; i++) tick();
    i_fill_start = 1'b1;
    tick();
    i_fill_start = 1'b0;
    wait_ready(2000, ok);
    check("fill_ready_timeout", ok, 1'b1);
    check_fill("fill_red", 8'hF8, 8'h00);

    // Slow downstream: 500-cycle busy after every strobe.
    log_q.delete();
    log_cyc.delete();
    busy_len     = 500;
    i_color      = 16'h07E0;
    i_fill_start = 1'b1;
    tick();
    i_fill_start = 1'b0;
    wait_ready(12000, ok);
    check("slow_ready_timeout", ok, 1'b1);
    check_fill("fill_slow", 8'h07, 8'hE0);
    if (log_cyc.size() >= 2) begin
      int g = 1000000;
      for (int k = 1; k < log_cyc.size(); k++)
        if (log_cyc[k] - log_cyc[k-1] < g) g = log_cyc[k] - log_cyc[k-1];
      check_range("slow_min_gap", g, 501, 1000000);
    end
    busy_len = 3;

    // Reset asserted during a pixel strobe aborts at once and restarts init.
    log_q.delete();
    log_cyc.delete();
    i_color      = 16'hABCD;
    i_fill_start = 1'b1;
    tick();
    i_fill_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (log_q.size() >= 5 && o_data_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    check("midfill_strobe_timeout", ok, 1'b1);
    rst = 1'b1;
    #1;
    check("async_rst_data_rdy", o_data_rdy, 1'b0);
    check("async_rst_ready", o_ready, 1'b0);
    check("async_rst_data", o_data, 8'h00);
    repeat (3) tick();
    log_q.delete();
    log_cyc.delete();
    rst = 1'b0;
    ok  = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (log_q.size() >= 1) begin
        ok = 1'b1;
        break;
      end
    end
    check("restart_timeout", ok, 1'b1);
    check("restart_first", log_at(0), 9'h001);
    wait_ready(6000, ok);
    check("restart_ready_timeout", ok, 1'b1);
    check("restart_len", log_q.size(), 17);
    check("restart_last", log_at(16), 9'h029);

    check("waiting_violations", violations, 0);
    check_range("min_strobe_gap", min_gap, 3, 1000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/st7735s_init_seq.md
ST7735S_INIT_SEQ -- requirements
Module: st7735s_init_seq

Interface
REQ-001 Parameter c_CLKS_PER_MS, default 50000, i_clk cycles per millisecond of delay (50 MHz clock).
REQ-002 Parameter c_WIDTH, default 128, panel columns; c_HEIGHT, default 160, panel rows.
REQ-003 i_clk  input  1  system clock, all logic on rising edge.
REQ-004 i_rst  input  1  asynchronous active-high reset.
REQ-005 i_waiting  input  1  downstream st7735s SPI driver idle; a byte may be issued.
REQ-006 o_ncommand  output  1  0 = command byte, 1 = argument/pixel byte; drives st7735s i_ncommand.
REQ-007 o_data  output  8  byte to send; drives st7735s i_data.
REQ-008 o_data_rdy  output  1  one-cycle strobe, byte valid; drives st7735s i_data_rdy.
REQ-009 i_fill_start  input  1  one-cycle request to fill the whole panel with i_color.
REQ-010 i_color  input  16  RGB565 fill colour, sampled on the accepted i_fill_start.
REQ-011 o_ready  output  1  init complete, no fill in progress, i_fill_start accepted.

Function
REQ-012 After reset deassertion, the block SHALL issue the init table automatically, in order: 0x01 (cmd), wait 150 ms; 0x11 (cmd), wait 120 ms; 0x3A, 0x05; 0x36, 0x00; 0x2A, 0x00, 0x00, 0x00, c_WIDTH-1; 0x2B, 0x00, 0x00, 0x00, c_HEIGHT-1; 0x29 (cmd), wait 10 ms.
REQ-013 The first byte of each group is sent with o_ncommand=0; all following bytes in the group with o_ncommand=1.
REQ-014 States: IDLE, LOAD, SEND, HOLD, WAIT, DELAY, READY, FILL_CMD, FILL_PIX.
REQ-015 SEND: o_data_rdy=1 for exactly one cycle, only when i_waiting=1 was seen in the previous cycle; o_data and o_ncommand are stable from that cycle until the next strobe.
REQ-016 HOLD: the block ignores i_waiting for 2 cycles after the strobe, then WAIT holds until i_waiting=1 before the next byte or delay.
REQ-017 DELAY: down-counter loaded with ms*c_CLKS_PER_MS; it runs only after the preceding byte completes (i_waiting=1); the next byte is issued the cycle after the count reaches 0.
REQ-018 After the last init entry and its delay, the block enters READY with o_ready=1.
REQ-019 In READY, i_fill_start=1 latches i_color, clears o_ready the next cycle, sends 0x2C (cmd), then c_WIDTH*c_HEIGHT pixels as two argument bytes each, high byte first.
REQ-020 The pixel counter is 15 bits wide (20480 pixels at default size); the block returns to READY after the low byte of the last pixel completes.
REQ-021 i_fill_start is ignored in any state other than READY; i_color changes during a fill have no effect.
REQ-022 Minimum spacing between strobes is 3 cycles; the block never strobes while i_waiting=0.

Reset
REQ-023 Reset values: o_data_rdy=0, o_ncommand=0, o_data=0x00, o_ready=0; state=IDLE; all counters and the table index at 0.
REQ-024 Reset asserted mid-byte, mid-delay or mid-fill aborts immediately; after deassertion the full init table restarts from entry 0.

Structure
REQ-025 A shared package holds the state encoding, command opcodes (SWRESET, SLPOUT, COLMOD, MADCTL, CASET, RASET, DISPON, RAMWR) and the init table entry format {is_cmd, byte, delay_ms}.
REQ-026 The init table is a combinational case-ROM sub-module, st7735s_init_rom, indexed by a 5-bit entry address.
REQ-027 In the top-level bench, st7735s_init_seq drives an st7735s instance directly; no glue logic.

Verification (c_CLKS_PER_MS=10, c_WIDTH=4, c_HEIGHT=2)
REQ-028 Release reset, i_waiting model idle -> byte log is exactly the REQ-012 sequence with last CASET arg 0x03 and last RASET arg 0x01; gap after 0x01 is >=1500 cycles; o_ready rises after 0x29 plus 100 cycles.
REQ-029 In READY, pulse i_fill_start with i_color=0xF800 -> 0x2C cmd, then 16 args alternating 0xF8,0x00; o_ready returns to 1.
REQ-030 Pulse i_fill_start during init and again during a fill -> both ignored; the byte log is unchanged.
REQ-031 Downstream holds i_waiting=0 for 500 cycles after a strobe -> no further strobe until i_waiting=1; no byte lost or duplicated.
REQ-032 Assert i_rst in the middle of FILL_PIX -> o_data_rdy=0 asynchronously; after release the log restarts with 0x01.
